sram_controller: RTL and testbench
==================================

// Module: sram_controller
// PURPOSE
//  Data-memory controller serving the mem stage of the ARM pipeline. Converts
//  single-cycle 32-bit LDR/STR requests into two 16-bit accesses on an external
//  asynchronous SRAM. Deasserts ready while busy; top level freezes all pipeline
//  registers while ready=0.
// PARAMETERS
//  BASE_ADDR    1024  byte address mapped to SRAM word 0
//  WAIT_CYCLES  1     extra cycles each 16-bit phase holds addr/ctrl (0..7)
//  SRAM_AW      18    SRAM halfword address width
// PORTS
//  clk        in   1        system clock, rising edge
//  rst        in   1        synchronous reset, ACTIVE-LOW
//  wr_en      in   1        store request from mem stage
//  rd_en      in   1        load request from mem stage
//  address    in   32       byte address (word aligned)
//  wr_data    in   32       store data
//  rd_data    out  32       load data, valid while ready=1 in DONE
//  ready      out  1        0 = freeze pipeline
//  SRAM_DQ    inout 16      SRAM data bus
//  SRAM_ADDR  out  SRAM_AW  SRAM halfword address
//  SRAM_WE_N  out  1        write enable, active-low
//  SRAM_OE_N, SRAM_CE_N, SRAM_UB_N, SRAM_LB_N  out 1  held 0
// BEHAVIOUR
//  - One clock (clk); reset synchronous active-low on rst. rst=0 at any edge,
//    including mid-access: state<=IDLE, SRAM_WE_N=1, SRAM_ADDR=0, rd_data=0,
//    DQ hi-Z. ready=1 while no request.
//  - Word index w = (address - BASE_ADDR) >> 2 (32-bit subtract, wraps mod 2^32).
//    Low half at SRAM_ADDR = {w,1'b0}, high half at {w,1'b1}; truncate to SRAM_AW.
//  - FSM: IDLE -> (wr_en ? WR_LO : rd_en ? RD_LO : IDLE); WR_LO->WR_HI->DONE;
//    RD_LO->RD_HI->DONE; DONE->IDLE. Each LO/HI phase lasts WAIT_CYCLES+1 cycles
//    via a 3-bit counter cleared on phase entry.
//  - ready = ~(rd_en|wr_en) | (state==DONE) (combinational). ready is low for
//    1 + 2*(WAIT_CYCLES+1) cycles, then high exactly one cycle (DONE).
//  - Write: DQ driven with wr_data[15:0] in WR_LO, [31:16] in WR_HI; SRAM_WE_N=0
//    on all cycles of the phase except the last (address held stable, WE
//    rising before address change). With WAIT_CYCLES=0 WE_N is low the whole
//    single-cycle phase. DQ hi-Z in all other states.
//  - Read: SRAM_WE_N=1; DQ sampled at last cycle of RD_LO into rd_data[15:0],
//    of RD_HI into rd_data[31:16]. rd_data holds until next read completes.
//  - wr_en and rd_en both high: treated as write. Request fields latched on
//    IDLE exit; changes/deassertion mid-access ignored, access completes.
//  - Back-to-back: a request present in the cycle after DONE starts from IDLE
//    (one idle cycle with ready=0 before the next LO phase).
// CONFIGURATION
//  SRAM_READ_BUF_EN defined: 1-entry buffer holds last read word index+data,
//   valid bit. A read hitting a valid entry goes IDLE->DONE (ready low 1 cycle,
//   no SRAM cycles). Any write to the same index updates the buffer with
//   wr_data; reset clears valid.
//  Undefined: every read performs both SRAM phases; no buffer logic.
// TESTING
//  1 rst=0 two cycles mid-WR_HI -> state IDLE, WE_N=1, DQ=Z, ready=1 idle.
//  2 STR addr=1024 data=0xDEADBEEF, W=1 -> SRAM[0]=0xBEEF, SRAM[1]=0xDEAD,
//    ready low 5 cycles, high cycle 6.
//  3 LDR addr=1028 with SRAM[2]=0x1234,[3]=0xABCD -> rd_data=0xABCD1234 in DONE.
//  4 W=0: STR then LDR back-to-back same address -> ready low 3 cycles each,
//    readback equals stored value.
//  5 wr_en=rd_en=1 addr=1032 data=0x5 -> write performed, SRAM[4]=0x0005.
//  6 SRAM_READ_BUF_EN: LDR 1028 twice -> second ready low 1 cycle, no SRAM
//    address activity; STR 1028 0x77 then LDR -> 0x00000077.

Source files
------------

// File: rtl/sram_controller.sv
// Data-memory controller: splits 32-bit LDR/STR requests into two 16-bit accesses on an async SRAM.
// Optional 1-entry read buffer enabled by defining SRAM_READ_BUF_EN.
module sram_controller #(
  parameter int unsigned BASE_ADDR   = 1024,
  parameter int unsigned WAIT_CYCLES = 1,
  parameter int unsigned SRAM_AW     = 18
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wr_en,
  input  logic               rd_en,
  input  logic [31:0]        address,
  input  logic [31:0]        wr_data,
  output logic [31:0]        rd_data,
  output logic               ready,
  inout  wire  [15:0]        SRAM_DQ,
  output logic [SRAM_AW-1:0] SRAM_ADDR,
  output logic               SRAM_WE_N,
  output logic               SRAM_OE_N,
  output logic               SRAM_CE_N,
  output logic               SRAM_UB_N,
  output logic               SRAM_LB_N
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_WR_LO = 3'd1;
  localparam logic [2:0] S_WR_HI = 3'd2;
  localparam logic [2:0] S_RD_LO = 3'd3;
  localparam logic [2:0] S_RD_HI = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  localparam int unsigned WW       = SRAM_AW - 1;
  localparam logic [2:0]  LAST_CNT = 3'(WAIT_CYCLES);
  localparam logic [31:0] BASE     = 32'(BASE_ADDR);

  logic [2:0]    state_q, state_d;
  logic [2:0]    cnt_q, cnt_d;
  logic [WW-1:0] widx_q, widx_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [31:0]   rdata_q, rdata_d;

  logic [31:0]   offset;
  logic [WW-1:0] req_widx;
  logic          phase_last;
  logic          in_wr, in_lo, in_hi;
  logic          buf_hit;
  logic [31:0]   buf_rd_data;
  logic          unused_offset_bits;

  // Word index wraps modulo 2^32 and is then truncated to the SRAM word space.
  assign offset             = address - BASE;
  assign req_widx           = offset[SRAM_AW:2];
  assign unused_offset_bits = ^{offset[31:SRAM_AW+1], offset[1:0]};

  assign phase_last = (cnt_q == LAST_CNT);
  assign in_wr      = (state_q == S_WR_LO) || (state_q == S_WR_HI);
  assign in_lo      = (state_q == S_WR_LO) || (state_q == S_RD_LO);
  assign in_hi      = (state_q == S_WR_HI) || (state_q == S_RD_HI);

`ifdef SRAM_READ_BUF_EN
  logic          buf_valid_q, buf_valid_d;
  logic [WW-1:0] buf_idx_q, buf_idx_d;
  logic [31:0]   buf_data_q, buf_data_d;

  assign buf_hit     = buf_valid_q && (buf_idx_q == req_widx);
  assign buf_rd_data = buf_data_q;

  always_comb begin
    buf_valid_d = buf_valid_q;
    buf_idx_d   = buf_idx_q;
    buf_data_d  = buf_data_q;
    if (state_q == S_IDLE && wr_en && buf_hit) begin
      buf_data_d = wr_data;
    end
    if (state_q == S_RD_HI && phase_last) begin
      buf_valid_d = 1'b1;
      buf_idx_d   = widx_q;
      buf_data_d  = {SRAM_DQ, rdata_q[15:0]};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      buf_valid_q <= 1'b0;
      buf_idx_q   <= '0;
      buf_data_q  <= '0;
    end else begin
      buf_valid_q <= buf_valid_d;
      buf_idx_q   <= buf_idx_d;
      buf_data_q  <= buf_data_d;
    end
  end
`else
  assign buf_hit     = 1'b0;
  assign buf_rd_data = '0;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    widx_d  = widx_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (wr_en) begin
          state_d = S_WR_LO;
          widx_d  = req_widx;
          wdata_d = wr_data;
        end else if (rd_en) begin
          widx_d = req_widx;
          if (buf_hit) begin
            state_d = S_DONE;
            rdata_d = buf_rd_data;
          end else begin
            state_d = S_RD_LO;
          end
        end
      end
      S_WR_LO, S_WR_HI, S_RD_LO, S_RD_HI: begin
        if (phase_last) begin
          cnt_d = '0;
          case (state_q)
            S_WR_LO: state_d = S_WR_HI;
            S_RD_LO: begin
              state_d        = S_RD_HI;
              rdata_d[15:0]  = SRAM_DQ;
            end
            S_RD_HI: begin
              state_d        = S_DONE;
              rdata_d[31:16] = SRAM_DQ;
            end
            default: state_d = S_DONE;
          endcase
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      widx_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      widx_q  <= widx_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  always_comb begin
    SRAM_ADDR = '0;
    if (in_lo) SRAM_ADDR = {widx_q, 1'b0};
    if (in_hi) SRAM_ADDR = {widx_q, 1'b1};
  end

  // WE_N releases one cycle before the address moves; with no wait cycles it spans the whole phase.
  assign SRAM_WE_N = ~(in_wr && (!phase_last || (WAIT_CYCLES == 0)));
  assign SRAM_DQ   = in_wr ? ((state_q == S_WR_HI) ? wdata_q[31:16] : wdata_q[15:0]) : 'z;

  assign ready     = ~(rd_en | wr_en) | (state_q == S_DONE);
  assign rd_data   = rdata_q;
  assign SRAM_OE_N = 1'b0;
  assign SRAM_CE_N = 1'b0;
  assign SRAM_UB_N = 1'b0;
  assign SRAM_LB_N = 1'b0;

endmodule

// File: tb/tb_sram_controller.sv
// Directed bench for sram_controller: WAIT_CYCLES=1 instance (A) and WAIT_CYCLES=0 instance (B).
module tb_sram_controller;

`ifdef SRAM_READ_BUF_EN
  localparam int HIT_LOW = 1;
`else
  localparam int HIT_LOW = 5;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  int   checks = 0;
  int   errors = 0;

  logic        a_wr, a_rd, a_ready, a_we_n, a_oe_n, a_ce_n, a_ub_n, a_lb_n;
  logic [31:0] a_addr, a_wdata, a_rdata;
  logic [17:0] a_sa, a_last_wr_addr;
  wire  [15:0] a_dq;
  logic        b_wr, b_rd, b_ready, b_we_n, b_oe_n, b_ce_n, b_ub_n, b_lb_n;
  logic [31:0] b_addr, b_wdata, b_rdata;
  logic [17:0] b_sa;
  wire  [15:0] b_dq;

  logic [15:0] mem_a [0:1023];
  logic [15:0] mem_b [0:1023];
  logic        drv_a, drv_b;

  sram_controller #(.BASE_ADDR(1024), .WAIT_CYCLES(1), .SRAM_AW(18)) dut_a (
    .clk(clk), .rst(rst), .wr_en(a_wr), .rd_en(a_rd), .address(a_addr), .wr_data(a_wdata),
    .rd_data(a_rdata), .ready(a_ready), .SRAM_DQ(a_dq), .SRAM_ADDR(a_sa), .SRAM_WE_N(a_we_n),
    .SRAM_OE_N(a_oe_n), .SRAM_CE_N(a_ce_n), .SRAM_UB_N(a_ub_n), .SRAM_LB_N(a_lb_n));

  sram_controller #(.BASE_ADDR(1024), .WAIT_CYCLES(0), .SRAM_AW(18)) dut_b (
    .clk(clk), .rst(rst), .wr_en(b_wr), .rd_en(b_rd), .address(b_addr), .wr_data(b_wdata),
    .rd_data(b_rdata), .ready(b_ready), .SRAM_DQ(b_dq), .SRAM_ADDR(b_sa), .SRAM_WE_N(b_we_n),
    .SRAM_OE_N(b_oe_n), .SRAM_CE_N(b_ce_n), .SRAM_UB_N(b_ub_n), .SRAM_LB_N(b_lb_n));

  // SRAM models: drive only while the bench expects a read, capture writes mid-cycle.
  assign a_dq = (drv_a && a_we_n) ? mem_a[a_sa[9:0]] : 'z;
  assign b_dq = (drv_b && b_we_n) ? mem_b[b_sa[9:0]] : 'z;

  always @(negedge clk) begin
    if (!a_we_n) begin
      mem_a[a_sa[9:0]] = a_dq;
      a_last_wr_addr   = a_sa;
    end
    if (!b_we_n) mem_b[b_sa[9:0]] = b_dq;
  end

  task automatic access(input bit use_b, input logic wr, input logic rd, input logic [31:0] addr,
                        input logic [31:0] data, input bit perturb, output int low,
                        output int we_low, output int addr_act, output logic [31:0] rdata);
    bit done = 1'b0;
    low = 0; we_low = 0; addr_act = 0; rdata = '0;
    if (use_b) begin
      drv_b = rd & ~wr; b_wr = wr; b_rd = rd; b_addr = addr; b_wdata = data;
    end else begin
      drv_a = rd & ~wr; a_wr = wr; a_rd = rd; a_addr = addr; a_wdata = data;
    end
    for (int i = 0; i < 40 && !done; i++) begin
      #1;
      if (!(use_b ? b_we_n : a_we_n)) we_low++;
      if ((use_b ? b_sa : a_sa) != 18'd0) addr_act++;
      if (use_b ? b_ready : a_ready) begin
        rdata = use_b ? b_rdata : a_rdata;
        done  = 1'b1;
      end else begin
        low++;
        @(posedge clk); #1;
        if (perturb && i == 0) begin
          a_addr  = addr ^ 32'h40;
          a_wdata = ~data;
        end
      end
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL access_timeout: got no ready within 40 cycles, expected ready (addr %h)", addr);
    end
    @(posedge clk); #1;
    a_wr = 1'b0; a_rd = 1'b0; drv_a = 1'b0;
    b_wr = 1'b0; b_rd = 1'b0; drv_b = 1'b0;
  endtask

  task automatic apply_reset();
    rst = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b1;
  endtask

  task automatic test_reset();
    apply_reset();
    checks++; if (a_we_n !== 1'b1) begin errors++; $display("FAIL reset_we_n: got %b expected 1", a_we_n); end
    checks++; if (a_sa !== 18'd0) begin errors++; $display("FAIL reset_addr: got %h expected 0", a_sa); end
    checks++; if (a_rdata !== 32'd0) begin errors++; $display("FAIL reset_rd_data: got %h expected 0", a_rdata); end
    checks++; if (a_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", a_ready); end
    checks++; if ({a_oe_n, a_ce_n, a_ub_n, a_lb_n} !== 4'b0000) begin
      errors++; $display("FAIL reset_ctrl_pins: got %b expected 0000", {a_oe_n, a_ce_n, a_ub_n, a_lb_n});
    end
    checks++; if (b_we_n !== 1'b1 || b_ready !== 1'b1) begin
      errors++; $display("FAIL reset_b: got we_n=%b ready=%b expected 1 1", b_we_n, b_ready);
    end
  endtask

  task automatic test_write();
    int low, wel, act; logic [31:0] rd;
    mem_a[0] = 16'h0; mem_a[1] = 16'h0;
    access(1'b0, 1'b1, 1'b0, 32'd1024, 32'hDEADBEEF, 1'b0, low, wel, act, rd);
    checks++; if (low !== 5) begin errors++; $display("FAIL write_ready_low: got %0d expected 5", low); end
    checks++; if (wel !== 2) begin errors++; $display("FAIL write_we_low: got %0d expected 2", wel); end
    checks++; if (mem_a[0] !== 16'hBEEF) begin errors++; $display("FAIL write_lo: got %h expected BEEF", mem_a[0]); end
    checks++; if (mem_a[1] !== 16'hDEAD) begin errors++; $display("FAIL write_hi: got %h expected DEAD", mem_a[1]); end
  endtask

  task automatic test_read();
    int low, wel, act; logic [31:0] rd;
    mem_a[2] = 16'h1234; mem_a[3] = 16'hABCD;
    access(1'b0, 1'b0, 1'b1, 32'd1028, 32'd0, 1'b0, low, wel, act, rd);
    checks++; if (low !== 5) begin errors++; $display("FAIL read_ready_low: got %0d expected 5", low); end
    checks++; if (wel !== 0) begin errors++; $display("FAIL read_we_low: got %0d expected 0", wel); end
    checks++; if (rd !== 32'hABCD1234) begin errors++; $display("FAIL read_data: got %h expected ABCD1234", rd); end
    @(posedge clk); #1;
    checks++; if (a_rdata !== 32'hABCD1234) begin errors++; $display("FAIL read_hold: got %h expected ABCD1234", a_rdata); end
  endtask

  task automatic test_reset_mid_access();
    int low, wel, act; logic [31:0] rd;
    a_wr = 1'b1; a_addr = 32'd1024; a_wdata = 32'h11112222;
    @(posedge clk); @(posedge clk); @(posedge clk); #1;
    checks++; if (a_we_n !== 1'b0 || a_sa !== 18'd1) begin
      errors++; $display("FAIL mid_wr_hi: got we_n=%b addr=%h expected 0 00001", a_we_n, a_sa);
    end
    a_wr = 1'b0;
    apply_reset();
    checks++; if (a_we_n !== 1'b1 || a_sa !== 18'd0) begin
      errors++; $display("FAIL midreset_outputs: got we_n=%b addr=%h expected 1 00000", a_we_n, a_sa);
    end
    checks++; if (a_ready !== 1'b1 || a_rdata !== 32'd0) begin
      errors++; $display("FAIL midreset_ready_rd: got ready=%b rd=%h expected 1 0", a_ready, a_rdata);
    end
    access(1'b0, 1'b1, 1'b0, 32'd1024, 32'hDEADBEEF, 1'b0, low, wel, act, rd);
    checks++; if (low !== 5 || mem_a[0] !== 16'hBEEF || mem_a[1] !== 16'hDEAD) begin
      errors++; $display("FAIL midreset_restart: got low=%0d mem=%h%h expected 5 DEADBEEF", low, mem_a[1], mem_a[0]);
    end
  endtask

  task automatic test_wr_rd_both();
    int low, wel, act; logic [31:0] rd;
    mem_a[4] = 16'hFFFF; mem_a[5] = 16'hFFFF;
    access(1'b0, 1'b1, 1'b1, 32'd1032, 32'h5, 1'b0, low, wel, act, rd);
    checks++; if (mem_a[4] !== 16'h0005 || mem_a[5] !== 16'h0000) begin
      errors++; $display("FAIL both_write: got %h_%h expected 0000_0005", mem_a[5], mem_a[4]);
    end
    checks++; if (low !== 5 || wel !== 2) begin
      errors++; $display("FAIL both_timing: got low=%0d we_low=%0d expected 5 2", low, wel);
    end
  endtask

  task automatic test_latch();
    int low, wel, act; logic [31:0] rd;
    mem_a[6] = '0; mem_a[7] = '0; mem_a[38] = '0; mem_a[39] = '0;
    access(1'b0, 1'b1, 1'b0, 32'd1036, 32'h0BADF00D, 1'b1, low, wel, act, rd);
    checks++; if (mem_a[6] !== 16'hF00D || mem_a[7] !== 16'h0BAD) begin
      errors++; $display("FAIL latch_data: got %h_%h expected 0BAD_F00D", mem_a[7], mem_a[6]);
    end
    checks++; if (mem_a[38] !== 16'h0 || mem_a[39] !== 16'h0) begin
      errors++; $display("FAIL latch_addr: got %h_%h expected 0000_0000", mem_a[39], mem_a[38]);
    end
  endtask

  task automatic test_wrap();
    int low, wel, act; logic [31:0] rd;
    access(1'b0, 1'b1, 1'b0, 32'd1020, 32'hCAFEF00D, 1'b0, low, wel, act, rd);
    checks++; if (a_last_wr_addr !== 18'h3FFFF) begin
      errors++; $display("FAIL wrap_addr: got %h expected 3FFFF", a_last_wr_addr);
    end
    checks++; if (mem_a[1022] !== 16'hF00D || mem_a[1023] !== 16'hCAFE) begin
      errors++; $display("FAIL wrap_data: got %h_%h expected CAFE_F00D", mem_a[1023], mem_a[1022]);
    end
  endtask

  task automatic test_back_to_back();
    int low, wel, act; logic [31:0] rd;
    mem_b[8] = '0; mem_b[9] = '0;
    access(1'b1, 1'b1, 1'b0, 32'd1040, 32'h13572468, 1'b0, low, wel, act, rd);
    checks++; if (low !== 3 || wel !== 2) begin
      errors++; $display("FAIL b2b_write_timing: got low=%0d we_low=%0d expected 3 2", low, wel);
    end
    access(1'b1, 1'b0, 1'b1, 32'd1040, 32'd0, 1'b0, low, wel, act, rd);
    checks++; if (low !== 3) begin errors++; $display("FAIL b2b_read_low: got %0d expected 3", low); end
    checks++; if (rd !== 32'h13572468) begin errors++; $display("FAIL b2b_readback: got %h expected 13572468", rd); end
  endtask

  task automatic test_read_buffer();
    int low, wel, act; logic [31:0] rd;
    apply_reset();
    mem_a[2] = 16'h1234; mem_a[3] = 16'hABCD;
    access(1'b0, 1'b0, 1'b1, 32'd1028, 32'd0, 1'b0, low, wel, act, rd);
    checks++; if (low !== 5 || rd !== 32'hABCD1234) begin
      errors++; $display("FAIL buf_first_read: got low=%0d rd=%h expected 5 ABCD1234", low, rd);
    end
    access(1'b0, 1'b0, 1'b1, 32'd1028, 32'd0, 1'b0, low, wel, act, rd);
    checks++; if (low !== HIT_LOW || rd !== 32'hABCD1234) begin
      errors++; $display("FAIL buf_second_read: got low=%0d rd=%h expected %0d ABCD1234", low, rd, HIT_LOW);
    end
`ifdef SRAM_READ_BUF_EN
    checks++; if (act !== 0) begin errors++; $display("FAIL buf_no_sram_activity: got %0d cycles expected 0", act); end
`endif
    access(1'b0, 1'b1, 1'b0, 32'd1028, 32'h77, 1'b0, low, wel, act, rd);
    checks++; if (low !== 5 || mem_a[2] !== 16'h0077 || mem_a[3] !== 16'h0000) begin
      errors++; $display("FAIL buf_store: got low=%0d mem=%h_%h expected 5 0000_0077", low, mem_a[3], mem_a[2]);
    end
    access(1'b0, 1'b0, 1'b1, 32'd1028, 32'd0, 1'b0, low, wel, act, rd);
    checks++; if (low !== HIT_LOW || rd !== 32'h00000077) begin
      errors++; $display("FAIL buf_read_after_store: got low=%0d rd=%h expected %0d 00000077", low, rd, HIT_LOW);
    end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) begin
      mem_a[i] = '0;
      mem_b[i] = '0;
    end
    rst = 1'b1;
    a_wr = 1'b0; a_rd = 1'b0; a_addr = '0; a_wdata = '0; drv_a = 1'b0;
    b_wr = 1'b0; b_rd = 1'b0; b_addr = '0; b_wdata = '0; drv_b = 1'b0;
    a_last_wr_addr = '0;
    @(posedge clk); #1;
    test_reset();
    test_write();
    test_read();
    test_reset_mid_access();
    test_wr_rd_both();
    test_latch();
    test_wrap();
    test_back_to_back();
    test_read_buffer();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
